// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, the NOP encoding, fetch FSM states and opcodes.
package cpu_pkg;

  localparam int PC_W_DEF    = 10;
  localparam int INSTR_W_DEF = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  typedef enum logic [1:0] {
    START  = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stats.sv
// Fetch statistics: free-running 32-bit counters of captures, stall cycles and redirects.
module fetch_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_evt,
  input  logic        stall_evt,
  input  logic        flush_evt,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_stalls,
  output logic [31:0] stat_flushes
);

  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stalls_q,  stalls_d;
  logic [31:0] flushes_q, flushes_d;

  always_comb begin
    fetched_d = fetched_q + 32'(fetch_evt);
    stalls_d  = stalls_q  + 32'(stall_evt);
    flushes_d = flushes_q + 32'(flush_evt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      stalls_q  <= '0;
      flushes_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      stalls_q  <= stalls_d;
      flushes_q <= flushes_d;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_stalls  = stalls_q;
  assign stat_flushes = flushes_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, START/RUN/HALTED FSM and IF/ID register with stall/redirect handling.
// Define FETCH_STATS_EN to add the stat_fetched/stat_stalls/stat_flushes counter outputs.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int               PC_W     = PC_W_DEF,
  parameter int               INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               halt_req,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_target,
  output logic [PC_W-1:0]    read_addr,
  input  logic [INSTR_W-1:0] instr_data,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc4,
  output logic               if_id_valid,
  output logic               flush_id_ex
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        stat_fetched,
  output logic [31:0]        stat_stalls,
  output logic [31:0]        stat_flushes
`endif
);

  localparam logic [INSTR_W-1:0] NOP       = INSTR_W'(NOP_INSTR);
  localparam logic [PC_W-1:0]    WORD_MASK = ~PC_W'(3);

  fetch_state_t         state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   if_id_instr_q, if_id_instr_d;
  logic [PC_W-1:0]      if_id_pc4_q, if_id_pc4_d;
  logic                 if_id_valid_q, if_id_valid_d;
  logic [PC_W-1:0]      pc_plus4;

  assign pc_plus4 = pc_q + PC_W'(4);

  // Redirects outrank stall: the branch in EX is older than the jump in ID and the stalled instruction.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;

    case (state_q)
      START: begin
        state_d = RUN;
      end
      RUN: begin
        if (br_taken) begin
          pc_d          = br_target & WORD_MASK;
          if_id_instr_d = NOP;
          if_id_pc4_d   = '0;
          if_id_valid_d = 1'b0;
        end else if (jump) begin
          pc_d          = jump_target & WORD_MASK;
          if_id_instr_d = NOP;
          if_id_pc4_d   = '0;
          if_id_valid_d = 1'b0;
        end else if (!stall) begin
          pc_d          = pc_plus4;
          if_id_instr_d = instr_data;
          if_id_pc4_d   = pc_plus4;
          if_id_valid_d = 1'b1;
        end
        if (halt_req) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        if_id_instr_d = NOP;
        if_id_pc4_d   = '0;
        if_id_valid_d = 1'b0;
      end
      default: begin
        state_d = START;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= START;
      pc_q          <= RESET_PC;
      if_id_instr_q <= NOP;
      if_id_pc4_q   <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign read_addr   = pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_valid = if_id_valid_q;
  assign flush_id_ex = br_taken & (state_q == RUN);

`ifdef FETCH_STATS_EN
  logic run_cycle;
  logic fetch_evt, stall_evt, flush_evt;

  assign run_cycle = (state_q == RUN);
  assign flush_evt = run_cycle & (br_taken | jump);
  assign stall_evt = run_cycle & ~br_taken & ~jump & stall;
  assign fetch_evt = run_cycle & ~br_taken & ~jump & ~stall;

  fetch_stats u_stats (
    .clk          (clk),
    .reset        (reset),
    .fetch_evt    (fetch_evt),
    .stall_evt    (stall_evt),
    .flush_evt    (flush_evt),
    .stat_fetched (stat_fetched),
    .stat_stalls  (stat_stalls),
    .stat_flushes (stat_flushes)
  );
`else
  // Counter-free build: no statistics logic is generated.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations, then random traffic
// compared every cycle against a behavioural PC/IF-ID model driven by a local instruction ROM.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 32;
  localparam int ROM_WORDS = 256;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               stall = 1'b0;
  logic               halt_req = 1'b0;
  logic               br_taken = 1'b0;
  logic [PC_W-1:0]    br_target = '0;
  logic               jump = 1'b0;
  logic [PC_W-1:0]    jump_target = '0;
  logic [PC_W-1:0]    read_addr;
  logic [INSTR_W-1:0] instr_data;
  logic [INSTR_W-1:0] if_id_instr;
  logic [PC_W-1:0]    if_id_pc4;
  logic               if_id_valid;
  logic               flush_id_ex;
`ifdef FETCH_STATS_EN
  logic [31:0]        stat_fetched, stat_stalls, stat_flushes;
`endif

  logic [31:0] rom [ROM_WORDS];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: phase 0 = waiting one cycle after reset, 1 = fetching, 2 = halted.
  int          m_pc = 0, m_pc4 = 0, m_phase = 0;
  logic [31:0] m_instr = 32'h0;
  bit          m_valid = 1'b0;
  bit          model_ready = 1'b0;
  int unsigned m_fetched = 0, m_stalls = 0, m_flushes = 0;

  fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC('0)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .halt_req    (halt_req),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jump        (jump),
    .jump_target (jump_target),
    .read_addr   (read_addr),
    .instr_data  (instr_data),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .flush_id_ex (flush_id_ex)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched (stat_fetched),
    .stat_stalls  (stat_stalls),
    .stat_flushes (stat_flushes)
`endif
  );

  always #5 clk = ~clk;

  assign instr_data = rom[read_addr[PC_W-1:2]];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setIdle();
    reset = 1'b0; stall = 1'b0; halt_req = 1'b0;
    br_taken = 1'b0; br_target = '0; jump = 1'b0; jump_target = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit r, input bit st, input bit h, input bit b,
                               input int bt, input bit j, input int jt);
    reset = r; stall = st; halt_req = h; br_taken = b;
    br_target = PC_W'(bt); jump = j; jump_target = PC_W'(jt);
  endtask

  task automatic runUntil(input int addr);
    int n = 0;
    setIdle();
    while (read_addr !== PC_W'(addr) && n < 400) begin
      tick();
      n++;
    end
    checkOutput("reach_pc", 32'(read_addr), 32'(addr));
  endtask

  // Reference model: PC arithmetic modulo 1024, targets word-aligned, redirect > stall > advance.
  always @(posedge clk) begin
    if (reset) begin
      m_pc = 0; m_pc4 = 0; m_instr = 32'h0; m_valid = 1'b0; m_phase = 0;
      m_fetched = 0; m_stalls = 0; m_flushes = 0;
      model_ready = 1'b1;
    end else if (model_ready) begin
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (br_taken || jump) begin
          m_pc = br_taken ? (int'(br_target) / 4) * 4 : (int'(jump_target) / 4) * 4;
          m_instr = 32'h0; m_pc4 = 0; m_valid = 1'b0;
          m_flushes++;
        end else if (stall) begin
          m_stalls++;
        end else begin
          m_instr = rom[m_pc / 4];
          m_pc4   = (m_pc + 4) % 1024;
          m_valid = 1'b1;
          m_pc    = m_pc4;
          m_fetched++;
        end
        if (halt_req) m_phase = 2;
      end else begin
        m_instr = 32'h0; m_pc4 = 0; m_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, sampled well after the rising edge.
  always @(posedge clk) begin
    #3;
    if (model_ready) begin
      checkOutput("m_read_addr", 32'(read_addr), 32'(m_pc));
      checkOutput("m_if_id_instr", if_id_instr, m_instr);
      checkOutput("m_if_id_pc4", 32'(if_id_pc4), 32'(m_pc4));
      checkOutput("m_if_id_valid", 32'(if_id_valid), 32'(m_valid));
      checkOutput("m_flush_id_ex", 32'(flush_id_ex), 32'(br_taken && m_phase == 1));
`ifdef FETCH_STATS_EN
      checkOutput("m_stat_fetched", stat_fetched, m_fetched);
      checkOutput("m_stat_stalls", stat_stalls, m_stalls);
      checkOutput("m_stat_flushes", stat_flushes, m_flushes);
`endif
    end
  end

  initial begin
    #300000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < ROM_WORDS; i++) rom[i] = $urandom;
    rom[0]  = 32'h8C010000;
    rom[46] = 32'h8C0B0024;

    // 1: reset, START cycle, then sequential fetch
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    setIdle();
    #1;
    checkOutput("rst_read_addr", 32'(read_addr), 32'h000);
    checkOutput("rst_instr", if_id_instr, 32'h0);
    checkOutput("rst_valid", 32'(if_id_valid), 32'h0);
    checkOutput("rst_pc4", 32'(if_id_pc4), 32'h0);
    tick();
    checkOutput("start_read_addr", 32'(read_addr), 32'h000);
    checkOutput("start_valid", 32'(if_id_valid), 32'h0);
    tick();
    checkOutput("first_read_addr", 32'(read_addr), 32'h004);
    checkOutput("first_instr", if_id_instr, 32'h8C010000);
    checkOutput("first_valid", 32'(if_id_valid), 32'h1);
    checkOutput("first_pc4", 32'(if_id_pc4), 32'h004);
    for (int i = 2; i < 10; i++) begin
      tick();
      checkOutput("seq_read_addr", 32'(read_addr), 32'(4 * i));
    end

    // 2: one-cycle load-use stall at 0x0BC
    runUntil(32'h0BC);
    checkOutput("pre_stall_instr", if_id_instr, 32'h8C0B0024);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    tick();
    setIdle();
    checkOutput("stall_read_addr", 32'(read_addr), 32'h0BC);
    checkOutput("stall_instr", if_id_instr, 32'h8C0B0024);
    checkOutput("stall_valid", 32'(if_id_valid), 32'h1);
    tick();
    checkOutput("resume_read_addr", 32'(read_addr), 32'h0C0);

    // 3: taken branch at 0x0DC
    runUntil(32'h0DC);
    applyStimulus(0, 0, 0, 1, 32'h0E0, 0, 0);
    #1;
    checkOutput("br_flush", 32'(flush_id_ex), 32'h1);
    tick();
    setIdle();
    checkOutput("br_read_addr", 32'(read_addr), 32'h0E0);
    checkOutput("br_valid", 32'(if_id_valid), 32'h0);
    checkOutput("br_instr", if_id_instr, 32'h0);

    // 4: jump at 0x0E8, then branch beats jump and stall with a misaligned target
    runUntil(32'h0E8);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h100);
    tick();
    setIdle();
    checkOutput("jmp_read_addr", 32'(read_addr), 32'h100);
    checkOutput("jmp_valid", 32'(if_id_valid), 32'h0);
    tick();
    checkOutput("jmp_next_addr", 32'(read_addr), 32'h104);
    checkOutput("jmp_next_pc4", 32'(if_id_pc4), 32'h104);
    checkOutput("jmp_next_valid", 32'(if_id_valid), 32'h1);
    applyStimulus(0, 1, 0, 1, 32'h123, 1, 32'h200);
    tick();
    setIdle();
    checkOutput("prio_read_addr", 32'(read_addr), 32'h120);
    checkOutput("prio_valid", 32'(if_id_valid), 32'h0);

    // 5: wrap from 0x3FC, then reset during a stall
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h3FE);
    tick();
    setIdle();
    checkOutput("wrap_pre_addr", 32'(read_addr), 32'h3FC);
    tick();
    checkOutput("wrap_read_addr", 32'(read_addr), 32'h000);
    checkOutput("wrap_pc4", 32'(if_id_pc4), 32'h000);
    checkOutput("wrap_valid", 32'(if_id_valid), 32'h1);
    tick();
    checkOutput("wrap_next_addr", 32'(read_addr), 32'h004);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    tick();
    checkOutput("rst_stall_hold", 32'(read_addr), 32'h004);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    tick();
    setIdle();
    checkOutput("rst_stall_addr", 32'(read_addr), 32'h000);
    checkOutput("rst_stall_valid", 32'(if_id_valid), 32'h0);

    // 6: halt at 0x040, later branch ignored
    runUntil(32'h040);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    tick();
    setIdle();
    checkOutput("halt_read_addr", 32'(read_addr), 32'h044);
    checkOutput("halt_last_valid", 32'(if_id_valid), 32'h1);
    tick();
    checkOutput("halted_read_addr", 32'(read_addr), 32'h044);
    checkOutput("halted_valid", 32'(if_id_valid), 32'h0);
    applyStimulus(0, 0, 0, 1, 32'h200, 0, 0);
    #1;
    checkOutput("halted_flush", 32'(flush_id_ex), 32'h0);
    tick();
    setIdle();
    checkOutput("halted_br_addr", 32'(read_addr), 32'h044);

    // Random traffic checked by the model
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    for (int c = 0; c < 1500; c++) begin
      applyStimulus(($urandom_range(0, 149) == 0),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 1023)),
                    ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 1023)));
      tick();
    end
    setIdle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
